// File: rtl/bitty_timer_pkg.sv
// Shared definitions for the bitty_timer memory-mapped machine timer:
// register offsets, CTRL/STATUS bit positions and the byte-lane merge helper.
package bitty_timer_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_MTIME_LO = 3'd2,
        REG_MTIME_HI = 3'd3,
        REG_CMP_LO   = 3'd4,
        REG_CMP_HI   = 3'd5,
        REG_PRESC    = 3'd6,
        REG_RSVD     = 3'd7
    } reg_off_e;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_IE      = 1;
    localparam int unsigned CTRL_AUTOCLR = 2;
    localparam int unsigned STATUS_PEND  = 0;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitty_timer_presc.sv
// Prescaler for bitty_timer: emits one tick every presc+1 cycles while enabled,
// and holds its count at zero while disabled.
module bitty_timer_presc (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] presc,
    output logic        tick
);

    logic [15:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/bitty_timer.sv
// Memory-mapped machine timer on the data-RAM bus: prescaled 64-bit mtime,
// 64-bit compare, sticky PEND flag and registered interrupt. Reads are combinational.
module bitty_timer
    import bitty_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    logic [2:0]  ctrl, ctrl_next;
    logic        pend, pend_next;
    logic [63:0] mtime, mtime_base, mtime_next;
    logic [63:0] cmp, cmp_next;
    logic [15:0] presc, presc_next;
    logic        hit, wr, rd, match, tick;
    reg_off_e    off;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    assign hit   = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr    = hit && we_i;
    assign rd    = hit && !we_i;
    assign off   = reg_off_e'(addr_i[4:2]);
    assign match = (mtime >= cmp);

    bitty_timer_presc u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl[CTRL_EN]),
        .presc (presc),
        .tick  (tick)
    );

    // mtime_base is the counter's own next value; bus lanes are merged over it
    // afterwards so a write beats both tick and AUTOCLR for the written bytes only.
    always_comb begin
        mtime_base = mtime;
        if (ctrl[CTRL_AUTOCLR] && match) begin
            mtime_base = '0;
        end else if (tick) begin
            mtime_base = mtime + 64'd1;
        end

        mtime_next = mtime_base;
        cmp_next   = cmp;
        ctrl_next  = ctrl;
        presc_next = presc;
        pend_next  = pend;

        if (wr) begin
            case (off)
                REG_CTRL: begin
                    if (sel_i[0]) ctrl_next = data_i[CTRL_AUTOCLR:CTRL_EN];
                end
                REG_STATUS: begin
                    if (sel_i[0] && data_i[STATUS_PEND]) pend_next = 1'b0;
                end
                REG_MTIME_LO: mtime_next[31:0]  = merge_lanes(mtime_base[31:0], data_i, sel_i);
                REG_MTIME_HI: mtime_next[63:32] = merge_lanes(mtime_base[63:32], data_i, sel_i);
                REG_CMP_LO:   cmp_next[31:0]    = merge_lanes(cmp[31:0], data_i, sel_i);
                REG_CMP_HI:   cmp_next[63:32]   = merge_lanes(cmp[63:32], data_i, sel_i);
                REG_PRESC: begin
                    if (sel_i[0]) presc_next[7:0]  = data_i[7:0];
                    if (sel_i[1]) presc_next[15:8] = data_i[15:8];
                end
                default: ;
            endcase
        end

        // Set beats a simultaneous write-1-to-clear.
        if (match) pend_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl  <= '0;
            pend  <= 1'b0;
            mtime <= '0;
            cmp   <= '1;
            presc <= '0;
            irq_o <= 1'b0;
        end else begin
            ctrl  <= ctrl_next;
            pend  <= pend_next;
            mtime <= mtime_next;
            cmp   <= cmp_next;
            presc <= presc_next;
            irq_o <= pend && ctrl[CTRL_IE];
        end
    end

    always_comb begin
        data_o = '0;
        if (rd) begin
            case (off)
                REG_CTRL:     data_o = {29'b0, ctrl};
                REG_STATUS:   data_o = {31'b0, pend};
                REG_MTIME_LO: data_o = mtime[31:0];
                REG_MTIME_HI: data_o = mtime[63:32];
                REG_CMP_LO:   data_o = cmp[31:0];
                REG_CMP_HI:   data_o = cmp[63:32];
                REG_PRESC:    data_o = {16'b0, presc};
                default:      data_o = '0;
            endcase
        end
    end

endmodule
